// File: rtl/hazard_unit.sv
// Hazard detection and operand-forwarding control for a five-stage MIPS-style pipeline.
// Defining HAZARD_PERF_CNT_EN adds the stall_count port and its saturating stall counter.
module hazard_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  fd_opcode,
    input  logic [5:0]  fd_funct,
    input  logic [4:0]  fd_rs,
    input  logic [4:0]  fd_rt,
    input  logic [4:0]  fd_rd,
    output logic        fd_stall,
    output logic        xm_stall,
    output logic [1:0]  d_fwd_sel1,
    output logic [1:0]  d_fwd_sel2,
    output logic [1:0]  x_fwd_sel_a,
    output logic [1:0]  x_fwd_sel_b
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0] stall_count
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;

    logic       isRtype, isJr, isShift, isLoad, isImm, isBranch;
    logic       src1Used, src2Used, decodeOp;
    logic [4:0] src1, src2, dest;

    logic       dxValid_q, dxValid_d, dxLoad_q, dxLoad_d;
    logic [4:0] dxDest_q, dxDest_d, dxSrc1_q, dxSrc1_d, dxSrc2_q, dxSrc2_d;
    logic       xmValid_q, xmLoad_q;
    logic [4:0] xmDest_q;
    logic       mwValid_q;
    logic [4:0] mwDest_q;

    logic       loadUse, decodeHaz;

    // Unused sources are forced to register 0 so they can never match a destination.
    always_comb begin
        isRtype  = (fd_opcode == OP_RTYPE);
        isJr     = isRtype && (fd_funct == FN_JR);
        isShift  = isRtype && ((fd_funct == FN_SLL) || (fd_funct == FN_SRL));
        isLoad   = (fd_opcode == OP_LW) || (fd_opcode == OP_LB);
        isImm    = (fd_opcode == OP_ADDI) || (fd_opcode == OP_ANDI) || (fd_opcode == OP_ORI) ||
                   (fd_opcode == OP_XORI) || (fd_opcode == OP_SLTI);
        isBranch = (fd_opcode == OP_BEQ) || (fd_opcode == OP_BNE);
        decodeOp = isBranch || isJr;
        src1Used = !((fd_opcode == OP_J) || (fd_opcode == OP_JAL) || isShift);
        src2Used = (isRtype && !isJr) || isBranch || (fd_opcode == OP_SW) || (fd_opcode == OP_SB);
        src1     = src1Used ? fd_rs : (isShift ? fd_rt : 5'd0);
        src2     = src2Used ? fd_rt : 5'd0;
        dest     = 5'd0;
        if (isRtype && !isJr) begin
            dest = fd_rd;
        end else if (isImm || isLoad) begin
            dest = fd_rt;
        end else if (fd_opcode == OP_JAL) begin
            dest = 5'd31;
        end
    end

    function automatic logic [1:0] fwdSel(input logic [4:0] src, input logic xmV, input logic xmL,
                                          input logic [4:0] xmD, input logic mwV, input logic [4:0] mwD);
        if ((src != 5'd0) && xmV && !xmL && (xmD == src)) return 2'd1;
        if ((src != 5'd0) && mwV && (mwD == src)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic decodeHit(input logic [4:0] src, input logic dxV, input logic [4:0] dxD,
                                       input logic xmV, input logic xmL, input logic [4:0] xmD);
        return (src != 5'd0) && ((dxV && (dxD == src)) || (xmV && xmL && (xmD == src)));
    endfunction

    always_comb begin
        loadUse   = dxValid_q && dxLoad_q && (dxDest_q != 5'd0) &&
                    ((src1 == dxDest_q) || (src2 == dxDest_q));
        decodeHaz = decodeOp &&
                    (decodeHit(src1, dxValid_q, dxDest_q, xmValid_q, xmLoad_q, xmDest_q) ||
                     decodeHit(src2, dxValid_q, dxDest_q, xmValid_q, xmLoad_q, xmDest_q));
        fd_stall    = loadUse || decodeHaz;
        xm_stall    = !xmValid_q;
        d_fwd_sel1  = fwdSel(src1, xmValid_q, xmLoad_q, xmDest_q, mwValid_q, mwDest_q);
        d_fwd_sel2  = fwdSel(src2, xmValid_q, xmLoad_q, xmDest_q, mwValid_q, mwDest_q);
        x_fwd_sel_a = fwdSel(dxSrc1_q, xmValid_q, xmLoad_q, xmDest_q, mwValid_q, mwDest_q);
        x_fwd_sel_b = fwdSel(dxSrc2_q, xmValid_q, xmLoad_q, xmDest_q, mwValid_q, mwDest_q);
    end

    // A stalled decode sends an all-zero bubble into the execute slot.
    always_comb begin
        dxValid_d = !fd_stall;
        dxLoad_d  = fd_stall ? 1'b0 : isLoad;
        dxDest_d  = fd_stall ? 5'd0 : dest;
        dxSrc1_d  = fd_stall ? 5'd0 : src1;
        dxSrc2_d  = fd_stall ? 5'd0 : src2;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dxValid_q <= 1'b0;
            dxLoad_q  <= 1'b0;
            dxDest_q  <= 5'd0;
            dxSrc1_q  <= 5'd0;
            dxSrc2_q  <= 5'd0;
            xmValid_q <= 1'b0;
            xmLoad_q  <= 1'b0;
            xmDest_q  <= 5'd0;
            mwValid_q <= 1'b0;
            mwDest_q  <= 5'd0;
        end else begin
            dxValid_q <= dxValid_d;
            dxLoad_q  <= dxLoad_d;
            dxDest_q  <= dxDest_d;
            dxSrc1_q  <= dxSrc1_d;
            dxSrc2_q  <= dxSrc2_d;
            xmValid_q <= dxValid_q;
            xmLoad_q  <= dxLoad_q;
            xmDest_q  <= dxDest_q;
            mwValid_q <= xmValid_q;
            mwDest_q  <= xmDest_q;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stallCount_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stallCount_q <= 16'd0;
        end else if (fd_stall && (stallCount_q != 16'hFFFF)) begin
            stallCount_q <= stallCount_q + 16'd1;
        end
    end

    assign stall_count = stallCount_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed pipeline sequences plus random instruction
// streams compared every cycle against a producer-lookup reference model.
module tb_hazard_unit;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] funct;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } instr_t;

    typedef struct packed {
        bit         valid;
        bit         load;
        bit         decodeUse;
        logic [4:0] dest;
        logic [4:0] s1;
        logic [4:0] s2;
    } slot_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  fdOpcode = '0;
    logic [5:0]  fdFunct = '0;
    logic [4:0]  fdRs = '0, fdRt = '0, fdRd = '0;
    logic        fdStall, xmStall;
    logic [1:0]  dSel1, dSel2, xSelA, xSelB;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stallCount;
`endif

    hazard_unit dut (
        .clock(clock), .reset(reset),
        .fd_opcode(fdOpcode), .fd_funct(fdFunct), .fd_rs(fdRs), .fd_rt(fdRt), .fd_rd(fdRd),
        .fd_stall(fdStall), .xm_stall(xmStall),
        .d_fwd_sel1(dSel1), .d_fwd_sel2(dSel2),
        .x_fwd_sel_a(xSelA), .x_fwd_sel_b(xSelB)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_count(stallCount)
`endif
    );

    always #5 clock = ~clock;

    int    checkCount = 0;
    int    passCount = 0;
    int    failCount = 0;
    slot_t pipe[3];
    int    expCount = 0;
    bit    curStall;
    slot_t curSlot;
    logic [1:0] lastD1, lastD2;

    function automatic instr_t mk(input int op, input int fn, input int rd, input int rs, input int rt);
        instr_t i;
        i.op = 6'(op); i.funct = 6'(fn); i.rd = 5'(rd); i.rs = 5'(rs); i.rt = 5'(rt);
        return i;
    endfunction

    // What the instruction reads and writes, straight from the ISA opcode table.
    function automatic slot_t decodeModel(input instr_t i);
        slot_t s;
        s = '0;
        s.valid = 1'b1;
        case (i.op)
            6'd0: begin
                if (i.funct == 6'd8) begin
                    s.s1 = i.rs; s.decodeUse = 1'b1;
                end else begin
                    s.s1 = (i.funct == 6'd0 || i.funct == 6'd2) ? i.rt : i.rs;
                    s.s2 = i.rt; s.dest = i.rd;
                end
            end
            6'd8, 6'd12, 6'd13, 6'd14, 6'd10: begin s.s1 = i.rs; s.dest = i.rt; end
            6'd35, 6'd32: begin s.s1 = i.rs; s.dest = i.rt; s.load = 1'b1; end
            6'd43, 6'd40: begin s.s1 = i.rs; s.s2 = i.rt; end
            6'd4, 6'd5:   begin s.s1 = i.rs; s.s2 = i.rt; s.decodeUse = 1'b1; end
            6'd2:         begin end
            6'd3:         s.dest = 5'd31;
            default:      s.s1 = i.rs;
        endcase
        return s;
    endfunction

    // Find the youngest in-flight producer of each source and ask whether its value is ready.
    function automatic bit needStall(input slot_t f);
        logic [4:0] srcs[2];
        srcs[0] = f.s1;
        srcs[1] = f.s2;
        for (int n = 0; n < 2; n++) begin
            if (srcs[n] == 5'd0) continue;
            for (int k = 0; k < 3; k++) begin
                if (pipe[k].valid && pipe[k].dest == srcs[n]) begin
                    if (k == 0 && pipe[0].load) return 1'b1;
                    if (f.decodeUse && (k == 0 || (k == 1 && pipe[1].load))) return 1'b1;
                    break;
                end
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [1:0] refFwd(input logic [4:0] s);
        if (s == 5'd0) return 2'd0;
        if (pipe[1].valid && !pipe[1].load && pipe[1].dest == s) return 2'd1;
        if (pipe[2].valid && pipe[2].dest == s) return 2'd2;
        return 2'd0;
    endfunction

    task automatic advanceModel(input slot_t f, input bit stall, input bit rst);
        if (rst) begin
            for (int k = 0; k < 3; k++) pipe[k] = '0;
            expCount = 0;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = stall ? slot_t'('0) : f;
            if (stall && expCount < 65535) expCount++;
        end
    endtask

    task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checkCount++;
        assert (got === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input instr_t ins);
        curSlot  = decodeModel(ins);
        curStall = needStall(curSlot);
        checkVal({tag, ".fd_stall"}, 16'(fdStall), 16'(curStall));
        checkVal({tag, ".xm_stall"}, 16'(xmStall), 16'(!pipe[1].valid));
        checkVal({tag, ".d_fwd_sel1"}, 16'(dSel1), 16'(refFwd(curSlot.s1)));
        checkVal({tag, ".d_fwd_sel2"}, 16'(dSel2), 16'(refFwd(curSlot.s2)));
        checkVal({tag, ".x_fwd_sel_a"}, 16'(xSelA), 16'(refFwd(pipe[0].s1)));
        checkVal({tag, ".x_fwd_sel_b"}, 16'(xSelB), 16'(refFwd(pipe[0].s2)));
`ifdef HAZARD_PERF_CNT_EN
        checkVal({tag, ".stall_count"}, stallCount, 16'(expCount));
`endif
    endtask

    task automatic setInputs(input instr_t ins);
        fdOpcode = ins.op; fdFunct = ins.funct; fdRs = ins.rs; fdRt = ins.rt; fdRd = ins.rd;
    endtask

    // Hold the instruction in decode until it is accepted; returns the number of stall cycles.
    task automatic applyStimulus(input string tag, input instr_t ins, output int stalls);
        bit done;
        done = 1'b0;
        stalls = 0;
        for (int c = 0; c < 6 && !done; c++) begin
            setInputs(ins);
            #1;
            checkOutput(tag, ins);
            if (!curStall) begin
                lastD1 = dSel1;
                lastD2 = dSel2;
            end
            @(posedge clock);
            advanceModel(curSlot, curStall, 1'b0);
            #1;
            if (curStall) stalls++;
            else done = 1'b1;
        end
        checkVal({tag, ".accepted"}, 16'(done), 16'd1);
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clock);
        advanceModel('0, 1'b0, 1'b1);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        int s;
        for (int k = 0; k < 3; k++) applyStimulus("nop", mk(0, 0, 0, 0, 0), s);
    endtask

    initial begin
        int s;
        instr_t nop, addDep, r;
        int ops[15];
        int fns[5];
        ops = '{0, 8, 12, 13, 14, 10, 35, 32, 43, 40, 4, 5, 2, 3, 63};
        fns = '{32, 34, 8, 0, 2};
        nop = mk(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) pipe[k] = '0;

        doReset();
        setInputs(nop);
        #1;
        checkVal("reset.fd_stall", 16'(fdStall), 16'd0);
        checkVal("reset.xm_stall", 16'(xmStall), 16'd1);
        checkVal("reset.sels", 16'({dSel1, dSel2, xSelA, xSelB}), 16'd0);

        $display("[TB] load followed by dependent ALU op");
        applyStimulus("lw2", mk(35, 0, 0, 1, 2), s);
        applyStimulus("add3", mk(0, 32, 3, 2, 4), s);
        checkVal("loadUse.stalls", 16'(s), 16'd1);
        setInputs(nop);
        #1;
        checkVal("loadUse.xm_stall", 16'(xmStall), 16'd1);
        checkVal("loadUse.x_fwd_sel_a", 16'(xSelA), 16'd2);
        drain();

        $display("[TB] BEQ after ALU write");
        applyStimulus("add5", mk(0, 32, 5, 1, 1), s);
        applyStimulus("beq5", mk(4, 0, 0, 5, 0), s);
        checkVal("aluBeq.stalls", 16'(s), 16'd1);
        checkVal("aluBeq.d_fwd_sel1", 16'(lastD1), 16'd1);
        checkVal("aluBeq.d_fwd_sel2", 16'(lastD2), 16'd0);
        drain();

        $display("[TB] BNE after load");
        doReset();
        applyStimulus("lw6", mk(35, 0, 0, 1, 6), s);
        applyStimulus("bne6", mk(5, 0, 0, 6, 7), s);
        checkVal("loadBne.stalls", 16'(s), 16'd2);
        checkVal("loadBne.d_fwd_sel1", 16'(lastD1), 16'd2);
`ifdef HAZARD_PERF_CNT_EN
        checkVal("loadBne.stall_count", stallCount, 16'd2);
`endif
        drain();

        $display("[TB] back-to-back writes of the same register");
        applyStimulus("add8a", mk(0, 32, 8, 1, 2), s);
        applyStimulus("add8b", mk(0, 32, 8, 3, 4), s);
        applyStimulus("sub9", mk(0, 34, 9, 8, 8), s);
        checkVal("younger.stalls", 16'(s), 16'd0);
        setInputs(nop);
        #1;
        checkVal("younger.x_fwd_sel_a", 16'(xSelA), 16'd1);
        checkVal("younger.x_fwd_sel_b", 16'(xSelB), 16'd1);
        drain();

        $display("[TB] register zero and shift source");
        applyStimulus("addi0", mk(8, 0, 0, 0, 0), s);
        applyStimulus("use0", mk(4, 0, 0, 0, 0), s);
        checkVal("zero.stalls", 16'(s), 16'd0);
        applyStimulus("lw11", mk(35, 0, 0, 1, 11), s);
        applyStimulus("sll10", mk(0, 0, 10, 0, 11), s);
        checkVal("shift.stalls", 16'(s), 16'd1);
        drain();

        $display("[TB] reset during a load-use stall");
        applyStimulus("lw2r", mk(35, 0, 0, 1, 2), s);
        addDep = mk(0, 32, 3, 2, 4);
        setInputs(addDep);
        #1;
        checkOutput("stallPre", addDep);
        reset = 1'b1;
        @(posedge clock);
        advanceModel('0, 1'b0, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        checkVal("midReset.fd_stall", 16'(fdStall), 16'd0);
        checkVal("midReset.xm_stall", 16'(xmStall), 16'd1);
        checkVal("midReset.sels", 16'({dSel1, dSel2, xSelA, xSelB}), 16'd0);
`ifdef HAZARD_PERF_CNT_EN
        checkVal("midReset.stall_count", stallCount, 16'd0);
`endif
        applyStimulus("addAfterReset", addDep, s);
        checkVal("midReset.noReplay", 16'(s), 16'd0);

        $display("[TB] random instruction stream");
        for (int n = 0; n < 300; n++) begin
            r = mk(ops[$urandom_range(0, 14)], fns[$urandom_range(0, 4)],
                   $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            applyStimulus("rand", r, s);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
